// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------------------------------------------------------------------
// MEM-stage initiator for a 32-bit data memory. It takes one load or store at
// a time over a valid/ready handshake. The memory is only ever accessed with
// whole words. This unit does all byte-lane selection and sign/zero extension
// itself. Sub-word stores are done as a read-modify-write of the whole word.
// Misaligned, out-of-range and illegal-funct3 requests are rejected without
// any memory access. Every accepted request gets exactly one registered
// response pulse.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a request; faults are answered from here
// LOAD   | word read in progress; extended lane registered into response
// STORE  | full-word write (sw)
// RMW_RD | read of the target word into the merge buffer (sb/sh)
// RMW_WR | write back of the merged word (sb/sh)
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_we                1 = store, 0 = load
//   req_funct3            RISC-V insn[14:12]
//   req_addr, req_wdata   byte address and store data
//   resp_valid            one-cycle response pulse
//   resp_rdata            extended load data; 0 for stores and faults
//   resp_fault            request rejected, memory untouched
//   mem_*                 word-only memory port; mem_rdata is combinational
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_buf;

    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_fault;

    logic                    w_accept;
    logic                    w_legal_f3;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_fault;

    logic [7:0]              w_load_byte;
    logic [15:0]             w_load_half;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_merge_data;

    // ------------------------------------------------------------------
    // Request decode and fault detection
    // ------------------------------------------------------------------
    assign req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_legal_f3 = 1'b0;
        if (req_we) begin
            w_legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                         (req_funct3 == 3'b010);
        end else begin
            w_legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                         (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                         (req_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size (00 byte, 01 half, 10 word).
    always_comb begin
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_out_of_range = |req_addr[31:ADDR_WIDTH];
    assign w_fault        = !w_legal_f3 || w_misaligned || w_out_of_range;

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_load_byte = 8'h00;
        case (r_addr[1:0])
            2'd0: w_load_byte = mem_rdata[7:0];
            2'd1: w_load_byte = mem_rdata[15:8];
            2'd2: w_load_byte = mem_rdata[23:16];
            2'd3: w_load_byte = mem_rdata[31:24];
            default: w_load_byte = 8'h00;
        endcase
    end

    assign w_load_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_load_data = '0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
            3'b001:  w_load_data = {{16{w_load_half[15]}}, w_load_half};
            3'b100:  w_load_data = {24'h000000, w_load_byte};
            3'b101:  w_load_data = {16'h0000, w_load_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Sub-word merge for the RMW write-back
    // ------------------------------------------------------------------
    always_comb begin
        w_merge_data = r_buf;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'd0: w_merge_data[7:0]   = r_wdata[7:0];
                2'd1: w_merge_data[15:8]  = r_wdata[7:0];
                2'd2: w_merge_data[23:16] = r_wdata[7:0];
                2'd3: w_merge_data[31:24] = r_wdata[7:0];
                default: w_merge_data = r_buf;
            endcase
        end else begin
            if (r_addr[1]) begin
                w_merge_data[31:16] = r_wdata[15:0];
            end else begin
                w_merge_data[15:0]  = r_wdata[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_fault) begin
                    if (!req_we) begin
                        w_next_state = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        w_next_state = S_STORE;
                    end else begin
                        w_next_state = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   w_next_state = S_IDLE;
            S_STORE:  w_next_state = S_IDLE;
            S_RMW_RD: w_next_state = S_RMW_WR;
            S_RMW_WR: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port, decoded from state. Everything is held at zero during
    // reset so a write cannot land in a reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        if (!reset) begin
            case (r_state)
                S_LOAD: begin
                    mem_read_en = 1'b1;
                    mem_address = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                end
                S_STORE: begin
                    mem_write_en = 1'b1;
                    mem_address  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata    = r_wdata;
                end
                S_RMW_RD: begin
                    mem_read_en = 1'b1;
                    mem_address = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                end
                S_RMW_WR: begin
                    mem_write_en = 1'b1;
                    mem_address  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata    = w_merge_data;
                end
                default: begin
                    mem_read_en  = 1'b0;
                    mem_write_en = 1'b0;
                end
            endcase
        end
    end

    assign mem_funct3 = 3'b010;

    // ------------------------------------------------------------------
    // State, request latch, merge buffer and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                        end else begin
                            r_we     <= req_we;
                            r_funct3 <= req_funct3;
                            r_addr   <= req_addr[ADDR_WIDTH-1:0];
                            r_wdata  <= req_wdata;
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                S_STORE: begin
                    r_resp_valid <= 1'b1;
                end
                S_RMW_RD: begin
                    r_buf <= mem_rdata;
                end
                S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;

    // r_we only documents the latched direction; state already encodes it.
    logic w_unused;
    assign w_unused = r_we;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int AW    = 12;
    localparam int WORDS = 1 << (AW - 2);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [AW-1:0] mem_address;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_read_en (mem_read_en),
        .mem_write_en(mem_write_en),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_funct3  (mem_funct3),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    // Word memory attached to the DUT: combinational read, write at the edge.
    logic [31:0] tmem [WORDS];
    assign mem_rdata = tmem[mem_address[AW-1:2]];
    always @(posedge clock) if (mem_write_en) tmem[mem_address[AW-1:2]] <= mem_wdata;

    // Reference memory image, updated by the model when a request is issued.
    logic [31:0] ref_mem [WORDS];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   rdata;
        logic          fault;
        int            cyc;
        int            nrd;
        int            nwr;
        logic [AW-1:0] maddr;
    } exp_t;

    exp_t sbq[$];
    int nchecks = 0;
    int nerr    = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: access rules written out as plain arithmetic.
    function automatic exp_t model(input bit we, input bit [2:0] f3,
                                   input bit [31:0] a, input bit [31:0] wd);
        exp_t e;
        bit legal, flt;
        int size, sh, idx, lat;
        logic [31:0] word, b, h, mask;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = int'(f3 & 3'd3);
        flt   = !legal || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0)
                || (a >= (32'd1 << AW));
        e.rdata = 32'h0;
        e.fault = flt;
        e.nrd = 0;
        e.nwr = 0;
        e.maddr = AW'((a / 4) * 4);
        lat = 1;
        if (!flt) begin
            idx  = int'(a / 4);
            sh   = int'(a % 4) * 8;
            word = ref_mem[idx];
            b = (word >> sh) & 32'hFF;
            h = (word >> sh) & 32'hFFFF;
            if (!we) begin
                lat = 2;
                e.nrd = 1;
                case (f3)
                    3'd0: e.rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
                    3'd1: e.rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'd4: e.rdata = b;
                    3'd5: e.rdata = h;
                    default: e.rdata = word;
                endcase
            end else if (f3 == 3'd2) begin
                lat = 2;
                e.nwr = 1;
                ref_mem[idx] = wd;
            end else begin
                lat = 3;
                e.nrd = 1;
                e.nwr = 1;
                mask = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
                ref_mem[idx] = (word & ~mask) | ((wd << sh) & mask);
            end
        end
        e.cyc = lat;
        return e;
    endfunction

    // Issue one request; when track is set, push the expected response.
    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit track);
        int waited = 0;
        exp_t e;
        @(negedge clock);
        while (!req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            nchecks++;
            nerr++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (track) begin
            e = model(we, f3, a, wd);
            e.cyc = cyc + e.cyc - 1;
            sbq.push_back(e);
        end
    endtask

    // Monitor: counts memory enables, pops and checks on each response.
    always @(negedge clock) begin
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
            if (mem_read_en || mem_write_en || resp_valid) begin
                nchecks++;
                nerr++;
                $display("FAIL reset_quiet: got rd=%0b wr=%0b rv=%0b expected 0", mem_read_en, mem_write_en, resp_valid);
            end
        end else begin
            if (mem_read_en) rd_cnt++;
            if (mem_write_en) wr_cnt++;
            if ((mem_read_en || mem_write_en) && sbq.size() > 0)
                chk("mem_address", 32'(mem_address), 32'(sbq[0].maddr));
            chk("mem_funct3", 32'(mem_funct3), 32'd2);
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk("read_cycles", 32'(rd_cnt), 32'(e.nrd));
                    chk("write_cycles", 32'(wr_cnt), 32'(e.nwr));
                    chk("ready_with_resp", 32'(req_ready), 32'd1);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                chk("idle_resp_zero", {resp_rdata[31:1], resp_rdata[0] | resp_fault}, 32'h0);
            end
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            tmem[i]    = $urandom;
            ref_mem[i] = tmem[i];
        end
        tmem[32'h10 >> 2] = 32'h8070F0FF; ref_mem[32'h10 >> 2] = 32'h8070F0FF;
        tmem[32'h20 >> 2] = 32'h11223344; ref_mem[32'h20 >> 2] = 32'h11223344;
        tmem[32'h50 >> 2] = 32'h00000000; ref_mem[32'h50 >> 2] = 32'h00000000;

        reset = 1'b1;
        @(negedge clock);
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_resp", {resp_rdata[31:2], resp_valid, resp_fault}, 32'h0);
        chk("reset_mem", {mem_wdata[31:2], mem_read_en, mem_write_en}, 32'h0);
        chk("reset_addr", 32'(mem_address), 32'h0);

        // Lane selection and extension
        issue(0, 3'b000, 32'h11, 0, 1);
        issue(0, 3'b100, 32'h11, 0, 1);
        issue(0, 3'b001, 32'h12, 0, 1);
        issue(0, 3'b101, 32'h12, 0, 1);
        issue(0, 3'b010, 32'h10, 0, 1);
        // Sub-word RMW
        issue(1, 3'b000, 32'h23, 32'h000000AA, 1);
        issue(0, 3'b010, 32'h20, 0, 1);
        issue(1, 3'b001, 32'h22, 32'h0000BEEF, 1);
        issue(0, 3'b010, 32'h20, 0, 1);
        // sw then back-to-back lw
        issue(1, 3'b010, 32'h40, 32'hDEADBEEF, 1);
        issue(0, 3'b010, 32'h40, 0, 1);
        // Faults
        issue(0, 3'b001, 32'h31, 0, 1);
        issue(0, 3'b010, 32'h42, 0, 1);
        issue(1, 3'b010, 32'h1001, 32'h12345678, 1);
        issue(0, 3'b011, 32'h40, 0, 1);
        issue(1, 3'b100, 32'h40, 0, 1);

        // Reset during RMW_WR of sb 0x55 @0x50: nothing tracked, memory unchanged.
        issue(1, 3'b000, 32'h50, 32'h00000055, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk("word50_after_reset", tmem[32'h50 >> 2], 32'h00000000);
        issue(0, 3'b010, 32'h50, 0, 1);

        // Randomized traffic, mostly in a small window to exercise overlap.
        for (int n = 0; n < 300; n++) begin
            bit [31:0] a;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 127);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1);
        end

        begin
            int w = 0;
            while (sbq.size() > 0 && w < 50) begin
                @(negedge clock);
                w++;
            end
            if (sbq.size() > 0) begin
                nchecks++;
                nerr++;
                $display("FAIL drain: got %0d pending responses expected 0", sbq.size());
            end
        end
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the 32-bit data memory port. Accepts one load/store request at a time from the pipeline over a valid/ready handshake. Drives the memory's read_en/write_en/address/data_in/funct3 inputs using word accesses only, and performs all byte-lane selection, sign/zero extension and sub-word read-modify-write itself. Returns exactly one registered response per accepted request and flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

## Interface
- ADDR_WIDTH, 12, byte-address width of the data memory (word index = bits [ADDR_WIDTH-1:2])
- DATA_WIDTH, 32, data word width; fixed at 32

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V insn[14:12]
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for sb/sh)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  request rejected, no memory access made
- mem_read_en  out  1  to memory read_en
- mem_write_en  out  1  to memory write_en
- mem_address  out  ADDR_WIDTH  word-aligned byte address, {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wdata  out  32  to memory data_in
- mem_funct3  out  3  constant 3'b010
- mem_rdata  in  32  from memory data_out; combinational, same cycle as address

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- Accept on clock edge with req_valid && req_ready. Latch we, funct3, addr, wdata.
- Legal load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal store funct3: 000 sb, 001 sh, 010 sw.
- Fault check at accept:
  - illegal funct3;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:ADDR_WIDTH]≠0.
  - On fault: stay in IDLE, resp_valid=1 and resp_fault=1 on the next cycle, no mem enable ever asserted.
- Transitions:
  - IDLE→LOAD for a legal load.
  - IDLE→STORE for sw.
  - IDLE→RMW_RD for sb/sh.
  - LOAD→IDLE.
  - STORE→IDLE.
  - RMW_RD→RMW_WR.
  - RMW_WR→IDLE.
- LOAD: mem_read_en=1. Select lane from mem_rdata by addr[1:0]: byte lane k = bits [8k+7:8k]; halfword lane = bits [15:0] or [31:16]. Sign-extend for lb/lh, zero-extend for lbu/lhu. Register the result into resp_rdata.
- STORE: mem_write_en=1, mem_wdata=req_wdata.
- RMW_RD: mem_read_en=1. Capture mem_rdata into the merge buffer.
- RMW_WR: mem_write_en=1. mem_wdata = buffer with the addressed byte/halfword lane replaced by req_wdata[7:0]/[15:0]; all other lanes unchanged.
- mem enables, mem_address and mem_wdata are decoded from state. Both enables are forced to 0 while reset=1, so no write lands in a reset cycle.
- mem_address is held stable from RMW_RD through RMW_WR.

## Timing
- Reset values: state=IDLE, req_ready=1 after reset deasserts (0 while reset=1), resp_valid=0, resp_rdata=0, resp_fault=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_wdata=0.
- Latency, counted from the accept edge E0:
  - load / sw: resp_valid high in the cycle after E1 (2 cycles);
  - sb/sh: resp_valid after E2 (3 cycles);
  - fault: resp_valid after E0 (1 cycle).
- The memory write for sw/sb/sh commits at the edge that leaves STORE or RMW_WR. resp_valid is high in the following cycle.
- req_ready is high in the same cycle as resp_valid, so a back-to-back request is accepted at that edge. Peak throughput: 1 load per 2 cycles.
- resp_valid is a single-cycle pulse with no backpressure. resp_rdata and resp_fault are valid only with it and are 0 otherwise.
- Reset asserted mid-operation: the pending op is abandoned, no response is issued, memory is unmodified if reset covers the STORE/RMW_WR cycle, and the unit is in IDLE with all outputs at reset values the next cycle.

## Test plan
- Preload word 0x10 = 0x8070F0FF. Load lb @0x11, lbu @0x11, lh @0x12, lhu @0x12, lw @0x10 -> resp_rdata 0xFFFFFFF0, 0x000000F0, 0xFFFF8070, 0x00008070, 0x8070F0FF. Each response 2 cycles after accept.
- Word 0x20 = 0x11223344. sb 0xAA @0x23 then lw @0x20 -> 0xAA223344. sh 0xBEEF @0x22 -> 0xBEEF3344. sb response arrives 3 cycles after accept, with exactly one read cycle then one write cycle.
- sw 0xDEADBEEF @0x40, then back-to-back lw @0x40 accepted in the response cycle -> 0xDEADBEEF.
- lh @0x31, lw @0x42, sw @0x1001 (ADDR_WIDTH=12), load funct3=011 -> resp_fault=1, resp_rdata=0, mem_read_en=mem_write_en=0 throughout, 1-cycle latency.
- Assert reset during RMW_WR of sb 0x55 @0x50 (word 0x00000000) -> mem_write_en stays 0, word remains 0x00000000, no resp_valid, req_ready=1 the cycle after reset drops.
